// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the EXE/MEM/WB sequencer and the ID interlock/bypass logic.
// A shadow entry is one pipeline writer; its width is $bits(shadow_t).
package pipe_hazard_ctrl_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RDY_W     = 3;

  // Bypass select codes consumed by the ID operand muxes
  localparam logic [1:0] FWD_SEL_RF  = 2'b00;
  localparam logic [1:0] FWD_SEL_EXE = 2'b01;
  localparam logic [1:0] FWD_SEL_MEM = 2'b10;
  localparam logic [1:0] FWD_SEL_WB  = 2'b11;

  // One-hot stage at which a writer's result becomes valid
  localparam logic [RDY_W-1:0] RDY_STAGE_EXE = 3'b001;
  localparam logic [RDY_W-1:0] RDY_STAGE_MEM = 3'b010;
  localparam logic [RDY_W-1:0] RDY_STAGE_WB  = 3'b100;

  typedef struct packed {
    logic                 wen;
    logic [RF_ADDR_W-1:0] addr;
    logic [RDY_W-1:0]     rdy;
  } shadow_t;

  typedef enum logic [1:0] {
    STG_EXE,
    STG_MEM,
    STG_WB
  } stage_e;

  // A result is available once the entry has reached (or passed) its ready stage.
  // WB always counts as ready: the write is landing this cycle.
  function automatic logic data_ready(input logic [RDY_W-1:0] rdy, input stage_e stg);
    logic [RDY_W-1:0] avail;
    case (stg)
      STG_EXE: avail = RDY_STAGE_EXE;
      STG_MEM: avail = RDY_STAGE_EXE | RDY_STAGE_MEM;
      default: avail = RDY_STAGE_EXE | RDY_STAGE_MEM | RDY_STAGE_WB;
    endcase
    return (stg == STG_WB) || (|(rdy & avail));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake/bus bundle between the ID stage logic and pipe_hazard_ctrl.
// Optional perf counters appear when PIPE_HAZARD_PERF_CNT_EN is defined.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic                 id_valid;
  logic [RF_ADDR_W-1:0] id_rj_addr;
  logic [RF_ADDR_W-1:0] id_rk_addr;
  logic                 id_rj_read;
  logic                 id_rk_read;
  logic [RF_ADDR_W-1:0] id_rd_addr;
  logic                 id_rf_wen;
  logic [RDY_W-1:0]     id_rdy_stage;
  logic                 exe_ready_go;
  logic                 mem_ready_go;
  logic                 wb_ready_go;
  logic                 flush;

  logic                 id_stall;
  logic                 id_allowin;
  logic                 id_to_exe_fire;
  logic                 exe_valid;
  logic                 mem_valid;
  logic                 wb_valid;
  logic                 exe_allowin;
  logic                 mem_allowin;
  logic                 wb_allowin;
  logic [1:0]           rj_fwd_sel;
  logic [1:0]           rk_fwd_sel;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0]          stall_cycles;
  logic [31:0]          load_use_stalls;
`endif

  modport master (
    output id_valid, id_rj_addr, id_rk_addr, id_rj_read, id_rk_read,
    output id_rd_addr, id_rf_wen, id_rdy_stage,
    output exe_ready_go, mem_ready_go, wb_ready_go, flush,
    input  id_stall, id_allowin, id_to_exe_fire,
    input  exe_valid, mem_valid, wb_valid,
    input  exe_allowin, mem_allowin, wb_allowin,
    input  rj_fwd_sel, rk_fwd_sel
`ifdef PIPE_HAZARD_PERF_CNT_EN
    , input stall_cycles, load_use_stalls
`endif
  );

  modport slave (
    input  id_valid, id_rj_addr, id_rk_addr, id_rj_read, id_rk_read,
    input  id_rd_addr, id_rf_wen, id_rdy_stage,
    input  exe_ready_go, mem_ready_go, wb_ready_go, flush,
    output id_stall, id_allowin, id_to_exe_fire,
    output exe_valid, mem_valid, wb_valid,
    output exe_allowin, mem_allowin, wb_allowin,
    output rj_fwd_sel, rk_fwd_sel
`ifdef PIPE_HAZARD_PERF_CNT_EN
    , output stall_cycles, load_use_stalls
`endif
  );

endinterface

// File: rtl/pipe_hazard_ctrl_src_hazard_chk.sv
// Per-source hazard check: finds the youngest in-flight writer of one ID source
// and either selects its bypass path or requests a stall if it is not ready yet.
module src_hazard_chk
  import pipe_hazard_ctrl_pkg::*;
(
  input  shadow_t              exe_sh,
  input  shadow_t              mem_sh,
  input  shadow_t              wb_sh,
  input  logic                 exe_valid,
  input  logic                 mem_valid,
  input  logic                 wb_valid,
  input  logic [RF_ADDR_W-1:0] src_addr,
  input  logic                 src_read,
  output logic [1:0]           fwd_sel,
  output logic                 stall
);

  function automatic logic hit(input logic vld, input shadow_t sh,
                               input logic [RF_ADDR_W-1:0] addr, input logic rd);
    return vld & sh.wen & (sh.addr != '0) & (sh.addr == addr) & rd;
  endfunction

  logic exe_hit;
  logic mem_hit;
  logic wb_hit;

  // Youngest match wins; an unready youngest match stalls without falling back
  always_comb begin
    exe_hit = hit(exe_valid, exe_sh, src_addr, src_read);
    mem_hit = hit(mem_valid, mem_sh, src_addr, src_read);
    wb_hit  = hit(wb_valid,  wb_sh,  src_addr, src_read);
    fwd_sel = FWD_SEL_RF;
    stall   = 1'b0;
    if (exe_hit) begin
      if (data_ready(exe_sh.rdy, STG_EXE)) fwd_sel = FWD_SEL_EXE;
      else                                 stall   = 1'b1;
    end else if (mem_hit) begin
      if (data_ready(mem_sh.rdy, STG_MEM)) fwd_sel = FWD_SEL_MEM;
      else                                 stall   = 1'b1;
    end else if (wb_hit) begin
      if (data_ready(wb_sh.rdy, STG_WB))   fwd_sel = FWD_SEL_WB;
      else                                 stall   = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// EXE/MEM/WB sequencer plus ID interlock and bypass-select controller.
// Tracks stage valid bits and a writer shadow per stage; derives allowin chain,
// ID fire/stall and per-source bypass selects.
// Define PIPE_HAZARD_PERF_CNT_EN to add stall_cycles / load_use_stalls counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave hz
);

  logic    exe_valid_q, exe_valid_d;
  logic    mem_valid_q, mem_valid_d;
  logic    wb_valid_q,  wb_valid_d;
  shadow_t exe_sh_q,    exe_sh_d;
  shadow_t mem_sh_q,    mem_sh_d;
  shadow_t wb_sh_q,     wb_sh_d;

  logic       wb_allowin;
  logic       mem_allowin;
  logic       exe_allowin;
  logic       id_stall;
  logic       id_to_exe_fire;
  logic       rj_stall;
  logic       rk_stall;
  logic [1:0] rj_fwd_sel;
  logic [1:0] rk_fwd_sel;

  src_hazard_chk u_rj_chk (
    .exe_sh    (exe_sh_q),
    .mem_sh    (mem_sh_q),
    .wb_sh     (wb_sh_q),
    .exe_valid (exe_valid_q),
    .mem_valid (mem_valid_q),
    .wb_valid  (wb_valid_q),
    .src_addr  (hz.id_rj_addr),
    .src_read  (hz.id_rj_read),
    .fwd_sel   (rj_fwd_sel),
    .stall     (rj_stall)
  );

  src_hazard_chk u_rk_chk (
    .exe_sh    (exe_sh_q),
    .mem_sh    (mem_sh_q),
    .wb_sh     (wb_sh_q),
    .exe_valid (exe_valid_q),
    .mem_valid (mem_valid_q),
    .wb_valid  (wb_valid_q),
    .src_addr  (hz.id_rk_addr),
    .src_read  (hz.id_rk_read),
    .fwd_sel   (rk_fwd_sel),
    .stall     (rk_stall)
  );

  // Backpressure chain from WB toward ID, then the ID->EXE handshake
  always_comb begin
    wb_allowin     = !wb_valid_q  | hz.wb_ready_go;
    mem_allowin    = !mem_valid_q | (hz.mem_ready_go & wb_allowin);
    exe_allowin    = !exe_valid_q | (hz.exe_ready_go & mem_allowin);
    id_stall       = hz.id_valid & (rj_stall | rk_stall);
    id_to_exe_fire = hz.id_valid & !id_stall & exe_allowin & !hz.flush;
  end

  assign hz.wb_allowin     = wb_allowin;
  assign hz.mem_allowin    = mem_allowin;
  assign hz.exe_allowin    = exe_allowin;
  assign hz.id_stall       = id_stall;
  assign hz.id_to_exe_fire = id_to_exe_fire;
  assign hz.id_allowin     = !hz.id_valid | id_to_exe_fire;
  assign hz.exe_valid      = exe_valid_q;
  assign hz.mem_valid      = mem_valid_q;
  assign hz.wb_valid       = wb_valid_q;
  assign hz.rj_fwd_sel     = rj_fwd_sel;
  assign hz.rk_fwd_sel     = rk_fwd_sel;

  // Stage advance: each valid bit and its shadow move together; flush kills EXE only
  always_comb begin
    exe_valid_d = exe_valid_q;
    mem_valid_d = mem_valid_q;
    wb_valid_d  = wb_valid_q;
    exe_sh_d    = exe_sh_q;
    mem_sh_d    = mem_sh_q;
    wb_sh_d     = wb_sh_q;
    if (exe_allowin) begin
      exe_valid_d  = id_to_exe_fire;
      exe_sh_d.wen  = hz.id_rf_wen;
      exe_sh_d.addr = hz.id_rd_addr;
      exe_sh_d.rdy  = hz.id_rdy_stage;
    end
    if (hz.flush) exe_valid_d = 1'b0;
    if (mem_allowin) begin
      mem_valid_d = exe_valid_q & hz.exe_ready_go;
      mem_sh_d    = exe_sh_q;
    end
    if (wb_allowin) begin
      wb_valid_d = mem_valid_q & hz.mem_ready_go;
      wb_sh_d    = mem_sh_q;
    end
  end

  // Stage state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exe_valid_q <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      exe_sh_q    <= '0;
      mem_sh_q    <= '0;
      wb_sh_q     <= '0;
    end else begin
      exe_valid_q <= exe_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
      exe_sh_q    <= exe_sh_d;
      mem_sh_q    <= mem_sh_d;
      wb_sh_q     <= wb_sh_d;
    end
  end

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q,    stall_cycles_d;
  logic [31:0] load_use_stalls_q, load_use_stalls_d;
  logic        load_use_q,        load_use_d;
  logic        exe_is_load;

  // A load sitting in EXE is always the youngest match, so any read of its
  // destination is a load-use stall; count only its first cycle
  always_comb begin
    exe_is_load = exe_valid_q & exe_sh_q.wen & (exe_sh_q.addr != '0) &
                  (exe_sh_q.rdy == RDY_STAGE_MEM);
    load_use_d  = hz.id_valid & exe_is_load &
                  ((hz.id_rj_read & (hz.id_rj_addr == exe_sh_q.addr)) |
                   (hz.id_rk_read & (hz.id_rk_addr == exe_sh_q.addr)));
    stall_cycles_d    = stall_cycles_q + {31'b0, id_stall};
    load_use_stalls_d = load_use_stalls_q + {31'b0, load_use_d & !load_use_q};
  end

  // Performance counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q    <= '0;
      load_use_stalls_q <= '0;
      load_use_q        <= 1'b0;
    end else begin
      stall_cycles_q    <= stall_cycles_d;
      load_use_stalls_q <= load_use_stalls_d;
      load_use_q        <= load_use_d;
    end
  end

  assign hz.stall_cycles    = stall_cycles_q;
  assign hz.load_use_stalls = load_use_stalls_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed expectations per vector.
// Counter checks are included when PIPE_HAZARD_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rj, input logic rjr,
                        input logic [4:0] rk, input logic rkr,
                        input logic [4:0] rd, input logic wen, input logic [2:0] rdy);
    hz.id_valid     = v;
    hz.id_rj_addr   = rj;
    hz.id_rj_read   = rjr;
    hz.id_rk_addr   = rk;
    hz.id_rk_read   = rkr;
    hz.id_rd_addr   = rd;
    hz.id_rf_wen    = wen;
    hz.id_rdy_stage = rdy;
  endtask

  task automatic drain();
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'b000);
    repeat (3) tick();
  endtask

  task automatic chk_sel(input string tag, input logic [1:0] rj_exp,
                         input logic [1:0] rk_exp, input logic stall_exp);
    check({tag, ".rj_sel"}, 32'(hz.rj_fwd_sel), 32'(rj_exp));
    check({tag, ".rk_sel"}, 32'(hz.rk_fwd_sel), 32'(rk_exp));
    check({tag, ".stall"},  32'(hz.id_stall),   32'(stall_exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    reset           = 1'b0;
    hz.exe_ready_go = 1'b1;
    hz.mem_ready_go = 1'b1;
    hz.wb_ready_go  = 1'b1;
    hz.flush        = 1'b0;
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 3'b000);
    #1 reset = 1'b1;
    #2;
    check("rst.exe_valid",   32'(hz.exe_valid),   32'd0);
    check("rst.mem_valid",   32'(hz.mem_valid),   32'd0);
    check("rst.wb_valid",    32'(hz.wb_valid),    32'd0);
    check("rst.exe_allowin", 32'(hz.exe_allowin), 32'd1);
    check("rst.mem_allowin", 32'(hz.mem_allowin), 32'd1);
    check("rst.wb_allowin",  32'(hz.wb_allowin),  32'd1);
    check("rst.id_allowin",  32'(hz.id_allowin),  32'd1);
    chk_sel("rst", FWD_SEL_RF, FWD_SEL_RF, 1'b0);
    reset = 1'b0;

    // ALU result forwarded from EXE, MEM and WB
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, RDY_STAGE_EXE);
    #1 check("alu.fire0", 32'(hz.id_to_exe_fire), 32'd1);
    tick();
    id_set(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, RDY_STAGE_EXE);
    #1 chk_sel("alu.exe", FWD_SEL_EXE, FWD_SEL_RF, 1'b0);
    check("alu.fire1", 32'(hz.id_to_exe_fire), 32'd1);
    check("alu.exe_valid", 32'(hz.exe_valid), 32'd1);
    tick();
    id_set(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 3'b000);
    #1 chk_sel("alu.mem", FWD_SEL_MEM, FWD_SEL_EXE, 1'b0);
    tick();
    id_set(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 3'b000);
    #1 chk_sel("alu.wb", FWD_SEL_WB, FWD_SEL_MEM, 1'b0);
    hz.id_rj_read = 1'b0;
    hz.id_rk_read = 1'b0;
    #1 chk_sel("alu.noread", FWD_SEL_RF, FWD_SEL_RF, 1'b0);
    tick();
    drain();

    // Load-use: one stall, then bypass from MEM
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, RDY_STAGE_MEM);
    #1 check("ld.fire0", 32'(hz.id_to_exe_fire), 32'd1);
    tick();
    id_set(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, RDY_STAGE_EXE);
    #1 chk_sel("ld.c1", FWD_SEL_RF, FWD_SEL_RF, 1'b1);
    check("ld.c1.fire",      32'(hz.id_to_exe_fire), 32'd0);
    check("ld.c1.id_allowin", 32'(hz.id_allowin),    32'd0);
    tick();
    #1 chk_sel("ld.c2", FWD_SEL_RF, FWD_SEL_MEM, 1'b0);
    check("ld.c2.fire",      32'(hz.id_to_exe_fire), 32'd1);
    check("ld.c2.exe_valid", 32'(hz.exe_valid),      32'd0);
    check("ld.c2.mem_valid", 32'(hz.mem_valid),      32'd1);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    check("ld.stall_cycles",    hz.stall_cycles,    32'd1);
    check("ld.load_use_stalls", hz.load_use_stalls, 32'd1);
`endif
    tick();
    drain();

    // Youngest writer not ready: stall, no fallback to an older ready copy
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, RDY_STAGE_EXE);
    tick();
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, RDY_STAGE_WB);
    tick();
    id_set(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, RDY_STAGE_EXE);
    #1 chk_sel("yng.exe", FWD_SEL_RF, FWD_SEL_RF, 1'b1);
    check("yng.mem_valid", 32'(hz.mem_valid), 32'd1);
    tick();
    #1 chk_sel("yng.mem", FWD_SEL_RF, FWD_SEL_RF, 1'b1);
    tick();
    #1 chk_sel("yng.wb", FWD_SEL_WB, FWD_SEL_RF, 1'b0);
    check("yng.fire", 32'(hz.id_to_exe_fire), 32'd1);
    tick();
`ifdef PIPE_HAZARD_PERF_CNT_EN
    check("yng.stall_cycles",    hz.stall_cycles,    32'd3);
    check("yng.load_use_stalls", hz.load_use_stalls, 32'd1);
`endif
    drain();

    // WB backpressure with all stages full
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, RDY_STAGE_EXE);
    tick();
    hz.id_rd_addr = 5'd11;
    tick();
    hz.id_rd_addr = 5'd12;
    tick();
    hz.wb_ready_go = 1'b0;
    id_set(1'b1, 5'd12, 1'b1, 5'd10, 1'b1, 5'd13, 1'b1, RDY_STAGE_EXE);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp.wb_allowin",  32'(hz.wb_allowin),  32'd0);
      check("bp.mem_allowin", 32'(hz.mem_allowin), 32'd0);
      check("bp.exe_allowin", 32'(hz.exe_allowin), 32'd0);
      check("bp.id_allowin",  32'(hz.id_allowin),  32'd0);
      check("bp.valids", {29'd0, hz.exe_valid, hz.mem_valid, hz.wb_valid}, 32'd7);
      chk_sel("bp.hold", FWD_SEL_EXE, FWD_SEL_WB, 1'b0);
      tick();
    end
    hz.wb_ready_go = 1'b1;
    #1;
    check("bp.rel.wb_allowin",  32'(hz.wb_allowin),     32'd1);
    check("bp.rel.exe_allowin", 32'(hz.exe_allowin),    32'd1);
    check("bp.rel.fire",        32'(hz.id_to_exe_fire), 32'd1);
    tick();
    id_set(1'b1, 5'd12, 1'b1, 5'd11, 1'b1, 5'd14, 1'b1, RDY_STAGE_EXE);
    #1 chk_sel("bp.adv", FWD_SEL_MEM, FWD_SEL_WB, 1'b0);

    // Flush kills the transfer and EXE; MEM still takes the EXE entry
    hz.flush = 1'b1;
    #1;
    check("fl.fire",      32'(hz.id_to_exe_fire), 32'd0);
    check("fl.id_allowin", 32'(hz.id_allowin),    32'd0);
    tick();
    hz.flush = 1'b0;
    check("fl.exe_valid", 32'(hz.exe_valid), 32'd0);
    check("fl.mem_valid", 32'(hz.mem_valid), 32'd1);
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, RDY_STAGE_EXE);
    #1 check("r0.fire", 32'(hz.id_to_exe_fire), 32'd1);
    tick();
    id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd15, 1'b1, RDY_STAGE_EXE);
    #1 chk_sel("r0.read", FWD_SEL_RF, FWD_SEL_RF, 1'b0);
    check("r0.exe_valid", 32'(hz.exe_valid), 32'd1);
    hz.flush        = 1'b1;
    hz.exe_ready_go = 1'b0;
    #1;
    check("fl2.exe_allowin", 32'(hz.exe_allowin),    32'd0);
    check("fl2.fire",        32'(hz.id_to_exe_fire), 32'd0);
    tick();
    hz.flush        = 1'b0;
    hz.exe_ready_go = 1'b1;
    check("fl2.exe_valid", 32'(hz.exe_valid), 32'd0);
    check("fl2.mem_valid", 32'(hz.mem_valid), 32'd0);
    drain();

    // Asynchronous reset in the middle of a run with every stage full
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, RDY_STAGE_MEM);
    tick();
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd21, 1'b1, RDY_STAGE_EXE);
    tick();
    id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd22, 1'b1, RDY_STAGE_MEM);
    tick();
    id_set(1'b1, 5'd20, 1'b1, 5'd22, 1'b1, 5'd23, 1'b1, RDY_STAGE_EXE);
    #1 chk_sel("mrst.pre", FWD_SEL_WB, FWD_SEL_RF, 1'b1);
    reset = 1'b1;
    #1;
    check("mrst.valids", {29'd0, hz.exe_valid, hz.mem_valid, hz.wb_valid}, 32'd0);
    check("mrst.allowins", {29'd0, hz.exe_allowin, hz.mem_allowin, hz.wb_allowin}, 32'd7);
    check("mrst.id_allowin", 32'(hz.id_allowin), 32'd1);
    chk_sel("mrst", FWD_SEL_RF, FWD_SEL_RF, 1'b0);
`ifdef PIPE_HAZARD_PERF_CNT_EN
    check("mrst.stall_cycles",    hz.stall_cycles,    32'd0);
    check("mrst.load_use_stalls", hz.load_use_stalls, 32'd0);
`endif
    #1 reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
